// File: rtl/nibble_scatter.sv
// nibble_scatter
//   Write-side counterpart of the nibble selector. Each input beat carries up
//   to four 4-bit nibbles, each tagged with a destination nibble index 0..7.
//   The nibbles are scattered into a 32-bit accumulator. A word is committed
//   when the producer marks the beat LAST, or automatically once all eight
//   nibble positions have been written. The committed word is presented on a
//   valid/ready output and held until the consumer accepts it.
//
// Optional feature macro: NIBBLE_SCATTER_ERR_EN
//   When defined, adds a sticky ERR output. ERR is set after an accepted beat
//   in which two enabled lanes target the same nibble, or in which an enabled
//   lane targets a nibble already written earlier in the current word.
//   ERR is cleared only by RESET. Data behaviour is identical either way.
//
// Parameters
//   FILL_NIBBLE  value loaded into every nibble position at reset and after
//                each word is accepted
//
// Ports
//   CLK        in   sole clock, rising edge
//   RESET      in   synchronous, active-high reset
//   NIBBLE_IN  in   [3:0][3:0] lane data, lane i = NIBBLE_IN[i]
//   POS        in   [3:0][2:0] lane destination nibble index
//   MASK       in   [3:0] lane enables
//   LAST       in   commit the current word with this beat
//   IN_VALID   in   beat present
//   IN_READY   out  beat taken when IN_VALID && IN_READY
//   DATA_OUT   out  [31:0] assembled word (qualified by OUT_VALID)
//   OUT_VALID  out  DATA_OUT holds a committed word
//   OUT_READY  in   consumer takes the word when OUT_VALID && OUT_READY
//   ERR        out  sticky error flag (only with NIBBLE_SCATTER_ERR_EN)

module nibble_scatter #(
    parameter logic [3:0] FILL_NIBBLE = 4'h0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [3:0][3:0] NIBBLE_IN,
    input  logic [3:0][2:0] POS,
    input  logic [3:0]      MASK,
    input  logic            LAST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [31:0]     DATA_OUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY
`ifdef NIBBLE_SCATTER_ERR_EN
    ,
    output logic            ERR
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [7:0]  wm_q;
    logic [7:0]  wm_d;
    logic        beat_acc;
    logic        commit;

    // Beats are only taken while a word is being assembled; in HOLD the
    // producer is stalled until the held word has been accepted.
    assign IN_READY  = (state_q != HOLD);
    assign OUT_VALID = (state_q == HOLD);
    assign DATA_OUT  = acc_q;
    assign beat_acc  = IN_VALID && IN_READY;

    // Lanes are applied in ascending order so that when two enabled lanes
    // name the same position, the higher lane index is the one that sticks.
    always_comb begin
        acc_d = acc_q;
        wm_d  = wm_q;
        for (int i = 0; i < 4; i++) begin
            if (MASK[i]) begin
                acc_d[{POS[i], 2'b00} +: 4] = NIBBLE_IN[i];
                wm_d[POS[i]]                = 1'b1;
            end
        end
    end

    assign commit = LAST || (wm_d == 8'hFF);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            acc_q   <= {8{FILL_NIBBLE}};
            wm_q    <= 8'h00;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        acc_q <= acc_d;
                        wm_q  <= wm_d;
                        if (commit) begin
                            state_q <= HOLD;
                        end else if (MASK != 4'h0) begin
                            state_q <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // The accumulator is refilled on the acceptance edge so
                    // the next word starts clean with no extra cycle.
                    if (OUT_READY) begin
                        state_q <= IDLE;
                        acc_q   <= {8{FILL_NIBBLE}};
                        wm_q    <= 8'h00;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef NIBBLE_SCATTER_ERR_EN
    logic collide;
    logic overwrite;
    logic err_q;

    always_comb begin
        collide   = 1'b0;
        overwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (MASK[i]) begin
                if (wm_q[POS[i]]) begin
                    overwrite = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    if (MASK[j] && (POS[j] == POS[i])) begin
                        collide = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else if (beat_acc && (collide || overwrite)) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`endif

endmodule

// File: doc/nibble_scatter.md
# nibble_scatter

- Write-side counterpart of the nibble selector: takes up to four 4-bit nibbles per beat, each tagged with a destination nibble index 0–7, and scatters them into a 32-bit word.
- A word is committed either by the producer (LAST) or automatically once all eight nibbles are written, then presented on a valid/ready output and held until accepted.
- Sits between the nibble-level datapath and any 32-bit consumer (register file, bus writer).

## Interface
- FILL_NIBBLE, 4'h0, value loaded into every unwritten nibble position at reset and after each word is accepted.
- CLK  input  1  sole clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- NIBBLE_IN  input  [3:0][3:0]  lane i data = NIBBLE_IN[i].
- POS  input  [3:0][2:0]  lane i destination index k; nibble k = DATA_OUT[4k+3:4k].
- MASK  input  4  lane i enabled when MASK[i]=1.
- LAST  input  1  commit current word with this beat.
- IN_VALID  input  1  beat present.
- IN_READY  output  1  beat accepted when IN_VALID && IN_READY.
- DATA_OUT  output  32  assembled word.
- OUT_VALID  output  1  DATA_OUT holds a committed word.
- OUT_READY  input  1  consumer accepts when OUT_VALID && OUT_READY.
- ERR  output  1  present only with NIBBLE_SCATTER_ERR_EN; see Configuration.

## Operation
- Internal state: 32-bit accumulator ACC (drives DATA_OUT), 8-bit written mask WM, FSM {IDLE, ACCUM, HOLD}.
- IN_READY = 1 in IDLE and ACCUM, 0 in HOLD; combinational from state.
- On an accepted beat, for each lane i with MASK[i]=1: ACC nibble POS[i] <= NIBBLE_IN[i], WM[POS[i]] <= 1.
- Same-beat collision (two enabled lanes, same POS): highest lane index wins.
- A nibble written in an earlier beat of the same word is overwritten by a later beat.
- Commit condition on an accepted beat: LAST=1, or (WM | new bits) == 8'hFF.
- Transitions:
  - IDLE/ACCUM -> HOLD on an accepted beat meeting the commit condition.
  - IDLE -> ACCUM on an accepted beat with any enabled lane and no commit.
  - ACCUM stays ACCUM on an accepted beat with no commit.
  - An accepted beat with MASK=0 and LAST=0 changes nothing.
  - HOLD -> IDLE on OUT_VALID && OUT_READY; same edge ACC <= {8{FILL_NIBBLE}}, WM <= 0.
- MASK=0 with LAST=1 commits the word as is; in IDLE this emits {8{FILL_NIBBLE}}.
- OUT_VALID = 1 exactly in HOLD.
- DATA_OUT is stable for the whole HOLD period.
- DATA_OUT is visible but not qualified in IDLE/ACCUM.

## Timing
- Reset values (cycle after RESET sampled high): state IDLE, ACC = DATA_OUT = {8{FILL_NIBBLE}}, WM = 0, OUT_VALID = 0, IN_READY = 1, ERR = 0.
- RESET has priority over every other input.
- Reset during ACCUM or HOLD discards the partial or held word; no output handshake occurs.
- Latency: committing beat accepted at edge N -> OUT_VALID = 1 and final DATA_OUT from edge N through the acceptance edge.
- Output handshake completes at edge M -> IN_READY = 1 after edge M.
- The next beat is accepted no earlier than edge M+1; no same-cycle bypass.
- Maximum throughput: one word per 2 cycles.
- IN_VALID asserted while IN_READY=0: beat is not taken. The producer keeps NIBBLE_IN/POS/MASK/LAST stable until acceptance.
- OUT_READY may be high before OUT_VALID; no combinational path from OUT_READY to DATA_OUT.

## Configuration
- NIBBLE_SCATTER_ERR_EN defined:
  - Adds output ERR, sticky, cleared only by RESET.
  - ERR is set the cycle after an accepted beat with a same-beat collision among enabled lanes.
  - ERR is also set the cycle after an enabled lane targets a nibble whose WM bit is already set.
  - Data behaviour is unchanged.
- Not defined: ERR port and its logic are absent; collisions and overwrites are silently resolved as above.

## Test plan
- Reset, then one beat MASK=4'hF, POS={3,2,1,0}, NIBBLE_IN={A,B,C,D}, LAST=1 -> next cycle OUT_VALID=1, DATA_OUT=32'h0000ABCD, IN_READY=0.
- Two beats without LAST covering positions 0–3 then 4–7 with nibbles 1..8 -> auto-commit after the second beat, DATA_OUT=32'h87654321.
- Hold OUT_READY=0 for 5 cycles with IN_VALID=1 -> DATA_OUT stable, no beat accepted.
- OUT_READY=1 -> IDLE, DATA_OUT={8{FILL_NIBBLE}}.
- Same-beat collision: lanes 0 and 2 both POS=5, data 3 and 9, LAST=1 -> DATA_OUT[23:20]=4'h9; with NIBBLE_SCATTER_ERR_EN, ERR=1 next cycle and remains set.
- RESET asserted mid-ACCUM after writing nibble 0=F, then beat MASK=0, LAST=1 -> DATA_OUT=32'h00000000 (FILL_NIBBLE=0), ERR=0.
